// File: rtl/cci_mpf_if_pkg.sv
// Request/response payload types shared by the CCI-MPF interface and shims.
// Each struct carries its own valid bit as the MSB.
package cci_mpf_if_pkg;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [7:0]  mdata;
  } t_if_cci_c0_Tx;

  typedef struct packed {
    logic        valid;
    logic [15:0] addr;
    logic [31:0] data;
  } t_if_cci_c1_Tx;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } t_if_cci_c2_Tx;

  typedef struct packed {
    logic        valid;
    logic [31:0] data;
    logic [7:0]  mdata;
  } t_if_cci_c0_Rx;

  typedef struct packed {
    logic        valid;
    logic [7:0]  mdata;
  } t_if_cci_c1_Rx;

endpackage

// File: rtl/cci_mpf_if.sv
// CCI-MPF bundle: to_fiu is the view of a shim facing the platform,
// to_afu is the view of a shim facing the user logic.
interface cci_mpf_if;
  import cci_mpf_if_pkg::*;

  logic          reset_n;
  t_if_cci_c0_Tx c0Tx;
  t_if_cci_c1_Tx c1Tx;
  t_if_cci_c2_Tx c2Tx;
  logic          c0TxAlmFull;
  logic          c1TxAlmFull;
  t_if_cci_c0_Rx c0Rx;
  t_if_cci_c1_Rx c1Rx;

  modport to_fiu (
    input  reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
    output c0Tx, c1Tx, c2Tx
  );

  modport to_afu (
    output reset_n, c0TxAlmFull, c1TxAlmFull, c0Rx, c1Rx,
    input  c0Tx, c1Tx, c2Tx
  );

endinterface

// File: rtl/cci_mpf_shim_tx_fifo.sv
// Request FIFO for one Tx channel with occupancy-based almost-full and a
// sticky overflow flag; the head entry is readable without a read strobe.
module cci_mpf_shim_tx_fifo #(
  parameter type T_DATA        = logic,
  parameter int  N_ENTRIES     = 16,
  parameter int  ALMFULL_SLACK = 8
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         enq_en_i,
  input  T_DATA                        enq_data_i,
  input  logic                         deq_en_i,
  output T_DATA                        first_o,
  output logic                         not_empty_o,
  output logic                         alm_full_o,
  output logic                         overflow_o,
  output logic [$clog2(N_ENTRIES):0]   occupancy_o
);

  localparam int PTR_W = $clog2(N_ENTRIES);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT    = CNT_W'(N_ENTRIES);
  localparam logic [CNT_W-1:0] ALMFULL_CNT = CNT_W'(N_ENTRIES - ALMFULL_SLACK);

  T_DATA             mem_q [N_ENTRIES];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              enq_ok;
  logic              deq_ok;

  // Fullness is judged on the pre-dequeue count, so a dequeue in the same
  // cycle never rescues an enqueue that arrives while full.
  always_comb begin
    enq_ok   = enq_en_i && (cnt_q != FULL_CNT);
    deq_ok   = deq_en_i && (cnt_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(enq_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(deq_ok);
    cnt_d    = cnt_q + CNT_W'(enq_ok) - CNT_W'(deq_ok);
    ovf_d    = ovf_q | (enq_en_i && !enq_ok);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem_q[wr_ptr_q] <= enq_data_i;
    end
  end

  assign first_o     = mem_q[rd_ptr_q];
  assign not_empty_o = (cnt_q != '0);
  assign alm_full_o  = (cnt_q >= ALMFULL_CNT);
  assign overflow_o  = ovf_q;
  assign occupancy_o = cnt_q;

endmodule

// File: rtl/cci_mpf_shim_tx_buffer.sv
// Buffers AFU c0/c1 requests in per-channel FIFOs and releases them to the
// FIU only while the FIU is not asserting almost-full on that channel.
module cci_mpf_shim_tx_buffer
  import cci_mpf_if_pkg::*;
#(
  parameter int N_ENTRIES     = 16,
  parameter int ALMFULL_SLACK = 8,
  parameter int REGISTER_RX   = 1
) (
  input  logic                        clk,
  input  logic                        reset_n,
  cci_mpf_if.to_fiu                   fiu,
  cci_mpf_if.to_afu                   afu,
  output logic                        c0_overflow,
  output logic                        c1_overflow,
  output logic [$clog2(N_ENTRIES):0]  c0_occupancy,
  output logic [$clog2(N_ENTRIES):0]  c1_occupancy
);

  t_if_cci_c0_Tx c0_head;
  t_if_cci_c1_Tx c1_head;
  logic          c0_not_empty, c1_not_empty;
  logic          c0_deq, c1_deq;
  logic          afu_reset_n_q;
  t_if_cci_c2_Tx c2_tx_q;

  assign c0_deq = c0_not_empty && !fiu.c0TxAlmFull;
  assign c1_deq = c1_not_empty && !fiu.c1TxAlmFull;

  cci_mpf_shim_tx_fifo #(
    .T_DATA(t_if_cci_c0_Tx), .N_ENTRIES(N_ENTRIES), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c0_fifo (
    .clk(clk), .reset_n(reset_n),
    .enq_en_i(afu.c0Tx.valid), .enq_data_i(afu.c0Tx), .deq_en_i(c0_deq),
    .first_o(c0_head), .not_empty_o(c0_not_empty), .alm_full_o(afu.c0TxAlmFull),
    .overflow_o(c0_overflow), .occupancy_o(c0_occupancy)
  );

  cci_mpf_shim_tx_fifo #(
    .T_DATA(t_if_cci_c1_Tx), .N_ENTRIES(N_ENTRIES), .ALMFULL_SLACK(ALMFULL_SLACK)
  ) u_c1_fifo (
    .clk(clk), .reset_n(reset_n),
    .enq_en_i(afu.c1Tx.valid), .enq_data_i(afu.c1Tx), .deq_en_i(c1_deq),
    .first_o(c1_head), .not_empty_o(c1_not_empty), .alm_full_o(afu.c1TxAlmFull),
    .overflow_o(c1_overflow), .occupancy_o(c1_occupancy)
  );

  // Valid comes from the dequeue decision, not from the stored copy.
  always_comb begin
    fiu.c0Tx       = c0_head;
    fiu.c0Tx.valid = c0_deq;
  end

  always_comb begin
    fiu.c1Tx       = c1_head;
    fiu.c1Tx.valid = c1_deq;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      afu_reset_n_q <= 1'b0;
      c2_tx_q       <= '0;
    end else begin
      afu_reset_n_q <= fiu.reset_n;
      c2_tx_q       <= afu.c2Tx;
    end
  end

  assign afu.reset_n = afu_reset_n_q;
  assign fiu.c2Tx    = c2_tx_q;

  if (REGISTER_RX != 0) begin : g_rx_reg
    t_if_cci_c0_Rx c0_rx_q;
    t_if_cci_c1_Rx c1_rx_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        c0_rx_q <= '0;
        c1_rx_q <= '0;
      end else begin
        c0_rx_q <= fiu.c0Rx;
        c1_rx_q <= fiu.c1Rx;
      end
    end

    assign afu.c0Rx = c0_rx_q;
    assign afu.c1Rx = c1_rx_q;
  end else begin : g_rx_pass
    assign afu.c0Rx = fiu.c0Rx;
    assign afu.c1Rx = fiu.c1Rx;
  end

endmodule
